// File: rtl/ram_pkg.sv
// Shared constants for the block-RAM FIFO slice.
// Provides the default RAM geometry (address/data width, depth), the
// almost-full threshold and the occupancy counter type. The FIFO
// controller, the RAM wrapper and the bench all use these.
package ram_pkg;

  localparam int unsigned RAM_ADDR_W   = 8;
  localparam int unsigned RAM_DATA_W   = 8;
  localparam int unsigned RAM_DEPTH    = 2 ** RAM_ADDR_W;
  localparam int unsigned RAM_AFULL_TH = 240;

  // Occupancy needs one extra bit so that a completely full RAM is representable.
  localparam int unsigned COUNT_W = RAM_ADDR_W + 1;
  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a simple dual-port block RAM
// (port A write, port B read, read latency 1, both ports on clka).
//
// Ports:
//   clka         clock, rising edge (also clocks the RAM ports)
//   rst          synchronous active-high reset
//   wr_en/wr_data    push request and data
//   rd_en            pop request
//   rd_data/rd_valid popped word (RAM doutb passthrough) and its strobe
//   full/empty/almost_full/count  occupancy status, all from registered count
//   wr_err/rd_err    one-cycle pulse for a push dropped when full /
//                    pop dropped when empty
//   ram_wea/ram_addra/ram_dina  RAM write port
//   ram_addrb/ram_doutb         RAM read port
module ram_fifo_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W   = RAM_ADDR_W,
  parameter int unsigned DATA_W   = RAM_DATA_W,
  parameter int unsigned AFULL_TH = RAM_AFULL_TH
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              wr_err,
  output logic              rd_err,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_doutb
);

  localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   AFULL_C = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  always_comb begin
    full        = (count == DEPTH_C);
    empty       = (count == '0);
    almost_full = (count >= AFULL_C);
    // Gating on registered flags keeps read and write slots disjoint:
    // empty blocks the read, full blocks the write.
    wr_ok       = wr_en & ~full;
    rd_ok       = rd_en & ~empty;
  end

  always_comb begin
    ram_wea   = wr_ok;
    ram_addra = wr_ptr;
    ram_dina  = wr_data;
    ram_addrb = rd_ptr;
    rd_data   = ram_doutb;
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // RAM read latency is one cycle, so the strobe lines up with doutb.
      rd_valid <= rd_ok;
      wr_err   <= wr_en & full;
      rd_err   <= rd_en & empty;
    end
  end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Single-clock FIFO controller that drives the 8-bit simple dual-port block RAM (port A write, port B read) as a first-in first-out buffer. Sits directly in front of the RAM: it accepts a push/pop stream from the producer/consumer, generates `wea`/`addra`/`dina` and `addrb`, and returns `doutb` to the consumer with a valid strobe. At the top level both RAM clocks (`clka`, `clkb`) are tied to this block's clock.

## Interface

Parameters:
- `ADDR_W`, 8, RAM address width; depth `DEPTH = 2**ADDR_W`
- `DATA_W`, 8, data width
- `AFULL_TH`, 240, `almost_full` asserts when `count >= AFULL_TH`

Ports:
- `clka`  in  1  clock (rising edge); also drives RAM `clka` and `clkb`
- `rst`  in  1  synchronous, active-high reset
- `wr_en`  in  1  push request
- `wr_data`  in  DATA_W  push data
- `rd_en`  in  1  pop request
- `rd_data`  out  DATA_W  popped data, valid when `rd_valid`
- `rd_valid`  out  1  one-cycle strobe, data of an accepted pop
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`
- `almost_full`  out  1  `count >= AFULL_TH`
- `count`  out  ADDR_W+1  current occupancy
- `wr_err`  out  1  one-cycle pulse: push dropped (full)
- `rd_err`  out  1  one-cycle pulse: pop dropped (empty)
- `ram_wea`  out  1  to RAM `wea`
- `ram_addra`  out  ADDR_W  to RAM `addra`
- `ram_dina`  out  DATA_W  to RAM `dina`
- `ram_addrb`  out  ADDR_W  to RAM `addrb`
- `ram_doutb`  in  DATA_W  from RAM `doutb`

## Operation

- Registers: `wr_ptr`, `rd_ptr` (ADDR_W, wrap modulo DEPTH), `count` (ADDR_W+1), `rd_valid`, `wr_err`, `rd_err`.
- Push accepted: `wr_ok = wr_en & ~full`. Pop accepted: `rd_ok = rd_en & ~empty`. Flags use registered `count`, never the same-cycle request.
- `ram_wea = wr_ok`, `ram_addra = wr_ptr`, `ram_dina = wr_data`, `ram_addrb = rd_ptr` (all combinational).
- On `wr_ok`: `wr_ptr <= wr_ptr + 1`. On `rd_ok`: `rd_ptr <= rd_ptr + 1`. Pointer 255 wraps to 0.
- `count`: +1 on `wr_ok & ~rd_ok`, −1 on `rd_ok & ~wr_ok`, unchanged otherwise.
- Simultaneous push+pop: when empty, push only, `rd_err` pulses; when full, pop only, `wr_err` pulses; otherwise both, count unchanged.
- `rd_data = ram_doutb` (passthrough); `rd_valid <= rd_ok`.
- Address collision impossible: a read never targets the slot written in the same cycle (empty blocks reads, full blocks writes).
- Reset: pointers, `count`, `rd_valid`, `wr_err`, `rd_err` to 0. Outputs after reset: `empty=1`, `full=0`, `almost_full=0`, `count=0`, `ram_wea=0`. A pop accepted in the reset cycle yields no `rd_valid`; FIFO contents are discarded logically (RAM is not cleared).

## Timing

- Push at edge N: data in RAM after edge N; `count`/`empty` update after edge N; earliest pop accepted in cycle N+1.
- Pop accepted at edge N: `rd_valid=1` and `rd_data` valid in cycle N+1 (RAM read latency 1, no output register).
- Back-to-back pops: one word per cycle, `rd_valid` continuous.
- Flags and `count` change only on the rising edge; `wr_err`/`rd_err` high exactly one cycle per dropped request.

## Structure

- Shared package `ram_pkg`: `ADDR_W`, `DATA_W`, `DEPTH` defaults and a `count_t` width constant, shared with the RAM wrapper and bench.
- No sub-module; a top `ram_fifo_top` (separate file) instantiates `ram_fifo_ctrl` and the RAM IP with `clka`/`clkb` tied.

## Test plan

- Reset, then push 10 values 0x11..0x1A on consecutive cycles -> `count=10`, `empty=0`; pop 10 -> `rd_data` 0x11..0x1A in order, `rd_valid` one cycle after each pop, then `empty=1`.
- Push 256 words (`data = i`) -> `full=1` at `count=256`, `almost_full` first high when `count=240`; extra push -> `wr_err` one pulse, `count` stays 256, `ram_wea=0`.
- From empty, `rd_en=1` -> `rd_err` pulse, `rd_valid=0`, pointers unchanged.
- Fill 5, then push+pop every cycle for 300 cycles -> `count` constant 5, pointers wrap past 255, output sequence equals input sequence delayed by 5 items.
- Full, assert push+pop together -> pop served, `wr_err` pulses, `count=255`; empty, push+pop together -> push served, `rd_err` pulses, `count=1`.
- Push 3 words, pop 1, assert `rst` in the same cycle as the next pop -> next cycle `rd_valid=0`, `count=0`, `empty=1`; new push 0xA5 then pop returns 0xA5.
